mac_rx_32b: RTL and testbench

//  Downstream consumer of the 32b PCS RX XGMII stream (xgmii32_t). Detects Start/preamble/SFD, strips them,

---
 rtl/gtype_pkg.sv | 31 +++
 rtl/mac_rx_32b_crc.sv | 35 +++
 rtl/mac_rx_32b.sv | 244 ++++++++++++++++++++++++
 tb/tb_mac_rx_32b.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gtype_pkg.sv
// Shared XGMII constants, stream and state types for the 32b MAC RX path.
// The CRC helper is only used when MAC_RX_CRC_CHECK_EN is defined.
package gtype;

  localparam logic [7:0]  XGMII_START   = 8'hFB;
  localparam logic [7:0]  XGMII_TERM    = 8'hFD;
  localparam logic [7:0]  XGMII_ERROR   = 8'hFE;
  localparam logic [7:0]  XGMII_IDLE    = 8'h07;
  localparam logic [31:0] PREAMBLE_SFD  = 32'hD5555555;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  ctrl;
    logic        ena;
  } xgmii32_t;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} mac_rx_state_t;

  // Reflected CRC-32 update by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_rx_32b_crc.sv
// CRC-32 accumulator over the emitted byte stream; present only with MAC_RX_CRC_CHECK_EN.
// crc shows the value including the current word when en is high, so the check needs no extra cycle.
`ifdef MAC_RX_CRC_CHECK_EN
module crc32_rx_32b
  import gtype::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic [31:0] din,
  input  logic [3:0]  keep,
  input  logic        en,
  output logic [31:0] crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_fold;

  always_comb begin
    crc_fold = crc_q;
    for (int b = 0; b < 4; b++) begin
      if (keep[b]) crc_fold = crc32_byte(crc_fold, din[8*b +: 8]);
    end
  end

  assign crc = en ? crc_fold : crc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      crc_q <= '1;
    else if (init) crc_q <= '1;
    else if (en)   crc_q <= crc_fold;
  end

endmodule
`endif

// File: rtl/mac_rx_32b.sv
// 32b XGMII receive deframer: strips Start/preamble/SFD, emits frame bytes with keep/last/err and stats.
// Define MAC_RX_CRC_CHECK_EN to add FCS checking and the stat_crc_err counter.
module mac_rx_32b
  import gtype::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 32
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             block_lock,
  input  xgmii32_t         xgmii_rx,
  output logic [31:0]      m_data,
  output logic [3:0]       m_keep,
  output logic             m_valid,
  output logic             m_last,
  output logic             m_err,
  output logic [CNT_W-1:0] stat_frames,
  output logic [CNT_W-1:0] stat_errors,
  output logic [CNT_W-1:0] stat_crc_err
);

  mac_rx_state_t state, state_nxt;

  logic [31:0] held_data, held_data_nxt;
  logic        held_vld, held_vld_nxt;
  logic        tail_pend, tail_pend_nxt;
  logic [31:0] tail_data, tail_data_nxt;
  logic [3:0]  tail_keep, tail_keep_nxt;
  logic [15:0] len_cnt;

  logic        start_w, fe_any, term_any;
  logic [1:0]  first_lane;
  logic [7:0]  first_byte;
  logic [3:0]  tail_keep_w;
  logic [31:0] tail_word;

  logic        o_valid, o_last, o_bad;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic        frame_start, do_close;

  logic [2:0]  keep_bytes;
  logic [16:0] len_wide;
  logic [15:0] len_sum;
  logic        len_err, crc_err, frame_err;

  assign start_w = xgmii_rx.ctrl[0] && (xgmii_rx.data[7:0] == XGMII_START);

  // Lowest control lane decides how a DATA word ends; FE in any control lane is fatal.
  always_comb begin
    first_lane = 2'd0;
    first_byte = xgmii_rx.data[7:0];
    fe_any     = 1'b0;
    term_any   = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (xgmii_rx.ctrl[k]) begin
        first_lane = 2'(k);
        first_byte = xgmii_rx.data[8*k +: 8];
        if (xgmii_rx.data[8*k +: 8] == XGMII_ERROR) fe_any = 1'b1;
        if (xgmii_rx.data[8*k +: 8] == XGMII_TERM)  term_any = 1'b1;
      end
    end
  end

  always_comb begin
    case (first_lane)
      2'd1:    tail_keep_w = 4'b0001;
      2'd2:    tail_keep_w = 4'b0011;
      2'd3:    tail_keep_w = 4'b0111;
      default: tail_keep_w = 4'b0000;
    endcase
    tail_word = xgmii_rx.data & {{8{tail_keep_w[3]}}, {8{tail_keep_w[2]}},
                                 {8{tail_keep_w[1]}}, {8{tail_keep_w[0]}}};
  end

  always_comb begin
    state_nxt     = state;
    o_valid       = 1'b0;
    o_data        = '0;
    o_keep        = '0;
    o_last        = 1'b0;
    o_bad         = 1'b0;
    held_data_nxt = held_data;
    held_vld_nxt  = held_vld;
    tail_pend_nxt = 1'b0;
    tail_data_nxt = tail_data;
    tail_keep_nxt = tail_keep;
    frame_start   = 1'b0;
    do_close      = 1'b0;

    if (tail_pend) begin
      o_valid = 1'b1;
      o_data  = tail_data;
      o_keep  = tail_keep;
      o_last  = 1'b1;
    end

    case (state)
      IDLE: begin
        if (block_lock && xgmii_rx.ena && start_w) state_nxt = PRE;
      end
      PRE: begin
        if (!block_lock) begin
          state_nxt = IDLE;
        end else if (xgmii_rx.ena) begin
          if (xgmii_rx.ctrl == 4'b0000 && xgmii_rx.data == PREAMBLE_SFD) begin
            state_nxt    = DATA;
            frame_start  = 1'b1;
            held_vld_nxt = 1'b0;
          end else begin
            state_nxt = DROP;
          end
        end
      end
      DATA: begin
        if (!block_lock) begin
          do_close  = 1'b1;
          state_nxt = IDLE;
        end else if (xgmii_rx.ena) begin
          if (xgmii_rx.ctrl == 4'b0000) begin
            if (held_vld) begin
              o_valid = 1'b1;
              o_data  = held_data;
              o_keep  = 4'hF;
            end
            held_data_nxt = xgmii_rx.data;
            held_vld_nxt  = 1'b1;
          end else if (fe_any || first_byte != XGMII_TERM) begin
            do_close  = 1'b1;
            state_nxt = start_w ? PRE : DROP;
          end else begin
            state_nxt    = IDLE;
            held_vld_nxt = 1'b0;
            o_valid      = 1'b1;
            if (first_lane == 2'd0) begin
              o_last = 1'b1;
              o_data = held_vld ? held_data : 32'h0;
              o_keep = held_vld ? 4'hF : 4'h0;
            end else if (held_vld) begin
              // Partial word follows the held word on the next cycle.
              o_data        = held_data;
              o_keep        = 4'hF;
              tail_pend_nxt = 1'b1;
              tail_data_nxt = tail_word;
              tail_keep_nxt = tail_keep_w;
            end else begin
              o_last = 1'b1;
              o_data = tail_word;
              o_keep = tail_keep_w;
            end
          end
        end
      end
      DROP: begin
        if (!block_lock) begin
          state_nxt = IDLE;
        end else if (xgmii_rx.ena) begin
          if (start_w)       state_nxt = PRE;
          else if (term_any) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (do_close) begin
      o_valid      = 1'b1;
      o_last       = 1'b1;
      o_bad        = 1'b1;
      o_data       = held_vld ? held_data : 32'h0;
      o_keep       = held_vld ? 4'hF : 4'h0;
      held_vld_nxt = 1'b0;
    end
  end

  assign keep_bytes = 3'(o_keep[0]) + 3'(o_keep[1]) + 3'(o_keep[2]) + 3'(o_keep[3]);
  assign len_wide   = {1'b0, len_cnt} + 17'(keep_bytes);
  assign len_sum    = len_wide[16] ? 16'hFFFF : len_wide[15:0];
  assign len_err    = o_last && ((len_sum < 16'(MIN_LEN)) || (len_sum > 16'(MAX_LEN)));

`ifdef MAC_RX_CRC_CHECK_EN
  logic [31:0] crc_val;

  crc32_rx_32b u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (frame_start),
    .din  (o_data),
    .keep (o_keep),
    .en   (o_valid),
    .crc  (crc_val)
  );

  assign crc_err = o_last && (crc_val != CRC32_RESIDUE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 stat_crc_err <= '0;
    else if (crc_err && stat_crc_err != '1)   stat_crc_err <= stat_crc_err + CNT_W'(1);
  end
`else
  assign crc_err      = 1'b0;
  assign stat_crc_err = '0;
`endif

  assign frame_err = o_last && (o_bad || len_err || crc_err);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      held_data   <= '0;
      held_vld    <= 1'b0;
      tail_pend   <= 1'b0;
      tail_data   <= '0;
      tail_keep   <= '0;
      len_cnt     <= '0;
      m_data      <= '0;
      m_keep      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_err       <= 1'b0;
      stat_frames <= '0;
      stat_errors <= '0;
    end else begin
      state     <= state_nxt;
      held_data <= held_data_nxt;
      held_vld  <= held_vld_nxt;
      tail_pend <= tail_pend_nxt;
      tail_data <= tail_data_nxt;
      tail_keep <= tail_keep_nxt;
      if (frame_start)  len_cnt <= '0;
      else if (o_valid) len_cnt <= len_sum;
      m_data  <= o_data;
      m_keep  <= o_keep;
      m_valid <= o_valid;
      m_last  <= o_last;
      m_err   <= frame_err;
      if (o_valid && o_last && stat_frames != '1) stat_frames <= stat_frames + CNT_W'(1);
      if (frame_err && stat_errors != '1)         stat_errors <= stat_errors + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mac_rx_32b.sv
// Directed bench for mac_rx_32b: framing, partial tails, errors, length limits, lock loss, reset, FCS.
// Expectations for the flipped-FCS frame follow whether MAC_RX_CRC_CHECK_EN is defined.
module tb_mac_rx_32b;
  import gtype::*;

`ifdef MAC_RX_CRC_CHECK_EN
  localparam logic CRC_EN = 1'b1;
`else
  localparam logic CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        block_lock;
  xgmii32_t    xgmii_rx;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid, m_last, m_err;
  logic [31:0] stat_frames, stat_errors, stat_crc_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] fb [0:1599];

  logic [7:0]  rx_bytes [$];
  logic [3:0]  w_keep [$];
  logic        w_last [$];
  logic        w_err [$];
  int          w_cyc [$];

  mac_rx_32b dut (
    .clk          (clk),
    .rst          (rst),
    .block_lock   (block_lock),
    .xgmii_rx     (xgmii_rx),
    .m_data       (m_data),
    .m_keep       (m_keep),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_err        (m_err),
    .stat_frames  (stat_frames),
    .stat_errors  (stat_errors),
    .stat_crc_err (stat_crc_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every emitted word away from the active edge.
  always @(negedge clk) begin
    if (m_valid === 1'b1) begin
      for (int b = 0; b < 4; b++) begin
        if (m_keep[b]) rx_bytes.push_back(m_data[8*b +: 8]);
      end
      w_keep.push_back(m_keep);
      w_last.push_back(m_last);
      w_err.push_back(m_err);
      w_cyc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [3:0] c, input logic e);
    xgmii_rx = '{data: d, ctrl: c, ena: e};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(32'h07070707, 4'b1111, 1'b1);
  endtask

  // Payload pattern plus little-endian FCS, optionally with one FCS bit flipped.
  task automatic build_frame(input int n, input logic flip);
    logic [31:0] c;
    logic        fbit;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n - 4; i++) begin
      fb[i] = 8'((i * 13 + n) & 255);
      for (int j = 0; j < 8; j++) begin
        fbit = c[0] ^ fb[i][j];
        c = c >> 1;
        if (fbit) c = c ^ 32'hEDB88320;
      end
    end
    c = ~c;
    for (int j = 0; j < 4; j++) fb[n - 4 + j] = c[8*j +: 8];
    if (flip) fb[n - 1] = fb[n - 1] ^ 8'h10;
  endtask

  function automatic logic [31:0] word_at(input int i);
    return {fb[4*i+3], fb[4*i+2], fb[4*i+1], fb[4*i]};
  endfunction

  task automatic send_head();
    applyStimulus(32'h555555FB, 4'b0001, 1'b1);
    applyStimulus(32'hD5555555, 4'b0000, 1'b1);
  endtask

  task automatic send_term(input int n);
    int          r;
    logic [31:0] d;
    logic [3:0]  c;
    r = n % 4;
    d = 32'h07070707;
    c = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      if (k < r) begin
        d[8*k +: 8] = fb[n - r + k];
        c[k] = 1'b0;
      end else if (k == r) begin
        d[8*k +: 8] = 8'hFD;
      end
    end
    applyStimulus(d, c, 1'b1);
  endtask

  task automatic send_frame(input int n);
    send_head();
    for (int i = 0; i < n / 4; i++) applyStimulus(word_at(i), 4'b0000, 1'b1);
    send_term(n);
  endtask

  function automatic int byte_mism(input int mark, input int n);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (mark + i >= rx_bytes.size()) cnt++;
      else if (rx_bytes[mark + i] !== fb[i]) cnt++;
    end
    return cnt;
  endfunction

  function automatic int lasts_from(input int wm);
    int cnt = 0;
    for (int i = wm; i < w_last.size(); i++) if (w_last[i]) cnt++;
    return cnt;
  endfunction

  initial begin
    int bm, wm, nw;
    rst        = 1'b0;
    block_lock = 1'b1;
    xgmii_rx   = '{data: 32'h07070707, ctrl: 4'b1111, ena: 1'b1};
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_last", 32'(m_last), 32'd0);
    checkOutput("rst_data", m_data, 32'd0);
    checkOutput("rst_frames", stat_frames, 32'd0);
    checkOutput("rst_errors", stat_errors, 32'd0);
    rst = 1'b1;
    idle(2);

    $display("[TB] 64B frame, terminate in lane0");
    build_frame(64, 1'b0);
    bm = rx_bytes.size(); wm = w_keep.size();
    send_head();
    for (int i = 0; i < 16; i++) applyStimulus(word_at(i), 4'b0000, 1'b1);
    send_term(64);
    @(negedge clk);
    checkOutput("t1_last_latency", 32'(m_valid & m_last), 32'd1);
    checkOutput("t1_err", 32'(m_err), 32'd0);
    idle(3);
    nw = w_keep.size() - wm;
    checkOutput("t1_words", 32'(nw), 32'd16);
    checkOutput("t1_bytes", 32'(rx_bytes.size() - bm), 32'd64);
    checkOutput("t1_data", 32'(byte_mism(bm, 64)), 32'd0);
    checkOutput("t1_one_last", 32'(lasts_from(wm)), 32'd1);
    checkOutput("t1_keep", 32'(w_keep[w_keep.size()-1]), 32'hF);
    checkOutput("t1_frames", stat_frames, 32'd1);

    $display("[TB] 65B frame, terminate in lane1");
    build_frame(65, 1'b0);
    bm = rx_bytes.size(); wm = w_keep.size();
    send_frame(65);
    idle(3);
    nw = w_keep.size() - wm;
    checkOutput("t2_words", 32'(nw), 32'd17);
    checkOutput("t2_tail_keep", 32'(w_keep[w_keep.size()-1]), 32'h1);
    checkOutput("t2_tail_last", 32'(w_last[w_last.size()-1]), 32'd1);
    checkOutput("t2_tail_gap", 32'(w_cyc[w_cyc.size()-1] - w_cyc[w_cyc.size()-2]), 32'd1);
    checkOutput("t2_err", 32'(w_err[w_err.size()-1]), 32'd0);
    checkOutput("t2_data", 32'(byte_mism(bm, 65)), 32'd0);
    checkOutput("t2_errors", stat_errors, 32'd0);
    checkOutput("t2_frames", stat_frames, 32'd2);

    $display("[TB] FE in lane2 of 5th data word");
    build_frame(64, 1'b0);
    bm = rx_bytes.size(); wm = w_keep.size();
    send_head();
    for (int i = 0; i < 4; i++) applyStimulus(word_at(i), 4'b0000, 1'b1);
    applyStimulus({fb[19], 8'hFE, fb[17], fb[16]}, 4'b0100, 1'b1);
    for (int i = 5; i < 8; i++) applyStimulus(word_at(i), 4'b0000, 1'b1);
    send_term(64);
    idle(3);
    checkOutput("t3_words", 32'(w_keep.size() - wm), 32'd4);
    checkOutput("t3_last", 32'(w_last[w_last.size()-1]), 32'd1);
    checkOutput("t3_err", 32'(w_err[w_err.size()-1]), 32'd1);
    checkOutput("t3_data", 32'(byte_mism(bm, 16)), 32'd0);
    checkOutput("t3_bytes", 32'(rx_bytes.size() - bm), 32'd16);
    checkOutput("t3_errors", stat_errors, 32'd1);

    $display("[TB] 60B runt and 1522B oversize frames");
    build_frame(60, 1'b0);
    bm = rx_bytes.size();
    send_frame(60);
    idle(3);
    checkOutput("t4_runt_bytes", 32'(rx_bytes.size() - bm), 32'd60);
    checkOutput("t4_runt_err", 32'(w_err[w_err.size()-1]), 32'd1);
    checkOutput("t4_runt_errors", stat_errors, 32'd2);
    build_frame(1522, 1'b0);
    bm = rx_bytes.size();
    send_frame(1522);
    idle(3);
    checkOutput("t4_big_bytes", 32'(rx_bytes.size() - bm), 32'd1522);
    checkOutput("t4_big_data", 32'(byte_mism(bm, 1522)), 32'd0);
    checkOutput("t4_big_keep", 32'(w_keep[w_keep.size()-1]), 32'h3);
    checkOutput("t4_big_err", 32'(w_err[w_err.size()-1]), 32'd1);
    checkOutput("t4_frames", stat_frames, 32'd5);
    checkOutput("t4_errors", stat_errors, 32'd3);

    $display("[TB] ena gaps then block_lock loss mid-frame");
    build_frame(64, 1'b0);
    bm = rx_bytes.size(); wm = w_keep.size();
    send_head();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(word_at(i), 4'b0000, 1'b1);
      if (i % 2 == 1) applyStimulus(32'h555555FB, 4'b0001, 1'b0);
    end
    block_lock = 1'b0;
    applyStimulus(word_at(6), 4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("t5_fall_last", 32'(m_valid & m_last), 32'd1);
    checkOutput("t5_fall_err", 32'(m_err), 32'd1);
    checkOutput("t5_fall_data", m_data, word_at(5));
    for (int i = 7; i < 16; i++) applyStimulus(word_at(i), 4'b0000, 1'b1);
    send_term(64);
    block_lock = 1'b1;
    idle(3);
    checkOutput("t5_words", 32'(w_keep.size() - wm), 32'd6);
    checkOutput("t5_data", 32'(byte_mism(bm, 24)), 32'd0);
    checkOutput("t5_errors", stat_errors, 32'd4);

    $display("[TB] asynchronous reset mid-frame");
    send_head();
    applyStimulus(word_at(0), 4'b0000, 1'b1);
    applyStimulus(word_at(1), 4'b0000, 1'b1);
    checkOutput("t5_pre_rst_valid", 32'(m_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t5_rst_valid", 32'(m_valid), 32'd0);
    checkOutput("t5_rst_data", m_data, 32'd0);
    checkOutput("t5_rst_keep", 32'(m_keep), 32'd0);
    checkOutput("t5_rst_frames", stat_frames, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(3);

    $display("[TB] FCS check");
    build_frame(64, 1'b0);
    send_frame(64);
    idle(3);
    checkOutput("t6_good_err", 32'(w_err[w_err.size()-1]), 32'd0);
    checkOutput("t6_good_crc", stat_crc_err, 32'd0);
    checkOutput("t6_good_frames", stat_frames, 32'd1);
    build_frame(64, 1'b1);
    send_frame(64);
    idle(3);
    checkOutput("t6_bad_err", 32'(w_err[w_err.size()-1]), 32'(CRC_EN));
    checkOutput("t6_bad_crc", stat_crc_err, 32'(CRC_EN));
    checkOutput("t6_errors", stat_errors, 32'(CRC_EN));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
